// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the M-stage data-memory interface:
// FSM state encoding, access-size codes and store lane steering.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_state_e;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_BYTE: lane_be = 4'b0001 << lane;
            MEM_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default:  lane_be = 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate the low byte/half so every enabled lane sees it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_BYTE: lane_wdata = {4{data[7:0]}};
            MEM_HALF: lane_wdata = {2{data[15:0]}};
            default:  lane_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data alignment: shifts the addressed byte/half of the bus word down
// to bit 0 and sign- or zero-extends it to 32 bits.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted_s;

    // Select and extend the addressed lane
    always_comb begin
        shifted_s = 32'd0;
        result_o  = 32'd0;
        case (size_i)
            MEM_BYTE: begin
                shifted_s = rdata_i >> {lane_i, 3'b000};
                result_o  = {{24{signed_i & shifted_s[7]}}, shifted_s[7:0]};
            end
            MEM_HALF: begin
                shifted_s = rdata_i >> {lane_i[1], 4'b0000};
                result_o  = {{16{signed_i & shifted_s[15]}}, shifted_s[15:0]};
            end
            default: begin
                shifted_s = rdata_i;
                result_o  = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage data-memory interface: req/gnt/rvalid bus FSM, store lane steering
// and registered load result. Optional macro: MEM_MISALIGN_TRAP_EN.
module memory_access_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignedM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    mem_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              misalign_q;

    logic              access_s;
    logic              misalign_s;
    logic [31:0]       ext_s;

    assign access_s = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = ((MemSizeM == MEM_HALF) && ALUOutM[0]) ||
                        (MemSizeM[1] && (ALUOutM[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata_i  (dmem_rdata),
        .lane_i   (ALUOutM[1:0]),
        .size_i   (MemSizeM),
        .signed_i (MemSignedM),
        .result_o (ext_s)
    );

    // Bus transaction FSM with registered bus fields and load result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_s && misalign_s) begin
                        misalign_q <= 1'b1;
                        rdata_q    <= '0;
                        state_q    <= DONE;
                    end else if (access_s) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM & ~MemReadM;
                        addr_q  <= {ALUOutM[ADDR_W-1:2], 2'b00};
                        wdata_q <= lane_wdata(MemSizeM, WriteDataM);
                        be_q    <= lane_be(MemSizeM, ALUOutM[1:0]);
                        state_q <= REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? DONE : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        rdata_q <= ext_s;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    misalign_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // DONE is the one cycle in which the pipeline is allowed to advance
    assign StallM     = reset & access_s & (state_q != DONE);
    assign ReadDataM  = rdata_q;
    assign MisalignM  = misalign_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule
